out_fifo_axis: RTL and testbench

//  Output result buffer between the MXU datapath and the PS-side AXI4-Stream DMA.

---
 rtl/out_fifo_axis_if.sv | 33 +++
 rtl/out_fifo_axis.sv | 136 +++++++++++++
 tb/tb_out_fifo_axis.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/out_fifo_axis_if.sv
// Bundles the push-side and AXI4-Stream signals of the output result buffer.
// The master view belongs to the buffer itself (it masters the stream);
// the slave view belongs to whatever feeds words in and sinks the stream.
interface out_fifo_axis_if #(
  parameter int unsigned DATA_WIDTH_FIFO_OUT = 64,
  parameter int unsigned FIFO_DEPTH_LOG2     = 4
);
  // push side (control_unit / MXU)
  logic [DATA_WIDTH_FIFO_OUT-1:0] din;
  logic                           wr_last;
  logic                           write;
  logic                           is_full;
  logic                           is_empty;
  logic [FIFO_DEPTH_LOG2:0]       count;
  logic                           overflow;
  // AXI4-Stream side (DMA)
  logic [DATA_WIDTH_FIFO_OUT-1:0] m_axis_tdata;
  logic                           m_axis_tvalid;
  logic                           m_axis_tlast;
  logic                           m_axis_tready;

  modport master (
    input  din, wr_last, write, m_axis_tready,
    output is_full, is_empty, count, overflow,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output din, wr_last, write, m_axis_tready,
    input  is_full, is_empty, count, overflow,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/out_fifo_axis.sv
// Output result buffer: first-word-fall-through FIFO between the MXU datapath
// and the AXI4-Stream DMA, with beat counting for TLAST framing.
// Occupancy flags are registered from the next-pointer values, so a push or
// pop becomes visible on the flags one cycle after the event.
module out_fifo_axis #(
  parameter int unsigned DATA_WIDTH_FIFO_OUT = 64,
  parameter int unsigned FIFO_DEPTH_LOG2     = 4,
  parameter int unsigned PKT_BEATS           = 16
) (
  input  logic            clk,
  input  logic            reset,   // asynchronous, active-low
  input  logic            clear,   // synchronous flush, active-high
  out_fifo_axis_if.master bus
);

  localparam int unsigned DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W   = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned ENTRY_W = DATA_WIDTH_FIFO_OUT + 1;
  localparam int unsigned BEAT_W  = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam logic        FRAME_BY_COUNT = (PKT_BEATS != 0);
  localparam logic [BEAT_W-1:0] BEAT_LAST =
    (PKT_BEATS != 0) ? BEAT_W'(PKT_BEATS - 1) : '0;

  // Full when the wrap bits differ and the index bits match.
  function automatic logic ptr_full(input logic [PTR_W-1:0] wr,
                                    input logic [PTR_W-1:0] rd);
    ptr_full = (wr[PTR_W-1] != rd[PTR_W-1]) &&
               (wr[PTR_W-2:0] == rd[PTR_W-2:0]);
  endfunction

  // Storage: entry = {wr_last, din}; deliberately not reset.
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic [ENTRY_W-1:0] head_s;
  logic               tvalid_s;
  logic               tlast_s;
  logic               beat_at_end_s;
  logic               push_s;
  logic               pop_s;

  // Head-of-queue view and handshake qualifiers.
  always_comb begin
    head_s        = mem_q[rd_ptr_q[FIFO_DEPTH_LOG2-1:0]];
    tvalid_s      = !empty_q;
    beat_at_end_s = FRAME_BY_COUNT && (beat_q == BEAT_LAST);
    tlast_s       = tvalid_s && (head_s[ENTRY_W-1] || beat_at_end_s);
    // No pass-through credit: a full FIFO refuses the push even if it pops now.
    push_s        = bus.write && !full_q;
    pop_s         = tvalid_s && bus.m_axis_tready;
  end

  // Next-state for pointers, beat counter, sticky overflow and occupancy flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_d     = beat_q;
    overflow_d = overflow_q;
    if (clear) begin
      // Flush wins over any push or pop in the same cycle.
      wr_ptr_d   = {PTR_W{1'b0}};
      rd_ptr_d   = {PTR_W{1'b0}};
      beat_d     = {BEAT_W{1'b0}};
      overflow_d = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (tlast_s) begin
          beat_d = {BEAT_W{1'b0}};
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end else begin
        rd_ptr_d = rd_ptr_q;
        beat_d   = beat_q;
      end
      if (bus.write && full_q) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
    count_d = wr_ptr_d - rd_ptr_d;
    full_d  = ptr_full(wr_ptr_d, rd_ptr_d);
    empty_d = (wr_ptr_d == rd_ptr_d);
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {PTR_W{1'b0}};
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      beat_q     <= {BEAT_W{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      beat_q     <= beat_d;
    end
  end

  // Storage write on an accepted push; a flush cycle never writes.
  always_ff @(posedge clk) begin
    if (push_s && !clear) begin
      mem_q[wr_ptr_q[FIFO_DEPTH_LOG2-1:0]] <= {bus.wr_last, bus.din};
    end
  end

  assign bus.is_full       = full_q;
  assign bus.is_empty      = empty_q;
  assign bus.count         = count_q;
  assign bus.overflow      = overflow_q;
  assign bus.m_axis_tdata  = head_s[DATA_WIDTH_FIFO_OUT-1:0];
  assign bus.m_axis_tvalid = tvalid_s;
  assign bus.m_axis_tlast  = tlast_s;

endmodule

// File: tb/tb_out_fifo_axis.sv
// Directed bench for out_fifo_axis: three instances (PKT_BEATS 16, 4, 0) share
// clock/reset/clear; one is selected at a time. A scoreboard queue holds the
// words expected on the stream, together with a small occupancy/framing model.
module tb_out_fifo_axis;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        clear;
  logic [1:0]  sel;
  logic [63:0] din;
  logic        wr_last;
  logic        write;
  logic        tready;

  logic [63:0] obs_tdata;
  logic        obs_tvalid, obs_tlast, obs_full, obs_empty, obs_ovf;
  logic [4:0]  obs_count;

  int   passed = 0;
  int   total  = 0;
  ent_t sb[$];
  int   mbeat  = 0;
  logic movf   = 1'b0;
  int   npop   = 0;
  int   nlast  = 0;
  int   base_pop, base_last;

  out_fifo_axis_if #(.DATA_WIDTH_FIFO_OUT(64), .FIFO_DEPTH_LOG2(4)) ia ();
  out_fifo_axis_if #(.DATA_WIDTH_FIFO_OUT(64), .FIFO_DEPTH_LOG2(4)) ib ();
  out_fifo_axis_if #(.DATA_WIDTH_FIFO_OUT(64), .FIFO_DEPTH_LOG2(4)) ic ();

  out_fifo_axis #(.DATA_WIDTH_FIFO_OUT(64), .FIFO_DEPTH_LOG2(4), .PKT_BEATS(16))
    u_a (.clk(clk), .reset(reset), .clear(clear), .bus(ia));
  out_fifo_axis #(.DATA_WIDTH_FIFO_OUT(64), .FIFO_DEPTH_LOG2(4), .PKT_BEATS(4))
    u_b (.clk(clk), .reset(reset), .clear(clear), .bus(ib));
  out_fifo_axis #(.DATA_WIDTH_FIFO_OUT(64), .FIFO_DEPTH_LOG2(4), .PKT_BEATS(0))
    u_c (.clk(clk), .reset(reset), .clear(clear), .bus(ic));

  assign ia.din = din;  assign ia.wr_last = wr_last;
  assign ib.din = din;  assign ib.wr_last = wr_last;
  assign ic.din = din;  assign ic.wr_last = wr_last;
  assign ia.write = write && (sel == 2'd0);
  assign ib.write = write && (sel == 2'd1);
  assign ic.write = write && (sel == 2'd2);
  assign ia.m_axis_tready = tready && (sel == 2'd0);
  assign ib.m_axis_tready = tready && (sel == 2'd1);
  assign ic.m_axis_tready = tready && (sel == 2'd2);

  // Observe the selected instance.
  always_comb begin
    case (sel)
      2'd1: begin
        obs_tdata = ib.m_axis_tdata; obs_tvalid = ib.m_axis_tvalid; obs_tlast = ib.m_axis_tlast;
        obs_full = ib.is_full; obs_empty = ib.is_empty; obs_ovf = ib.overflow; obs_count = ib.count;
      end
      2'd2: begin
        obs_tdata = ic.m_axis_tdata; obs_tvalid = ic.m_axis_tvalid; obs_tlast = ic.m_axis_tlast;
        obs_full = ic.is_full; obs_empty = ic.is_empty; obs_ovf = ic.overflow; obs_count = ic.count;
      end
      default: begin
        obs_tdata = ia.m_axis_tdata; obs_tvalid = ia.m_axis_tvalid; obs_tlast = ia.m_axis_tlast;
        obs_full = ia.is_full; obs_empty = ia.is_empty; obs_ovf = ia.overflow; obs_count = ia.count;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] o, input logic [64:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, " count"}, 65'(obs_count), 65'(sb.size()));
    chk({tag, " full"},  65'(obs_full),  65'(sb.size() == 16));
    chk({tag, " empty"}, 65'(obs_empty), 65'(sb.size() == 0));
    chk({tag, " ovf"},   65'(obs_ovf),   65'(movf));
  endtask

  function automatic void model_reset();
    sb.delete();
    mbeat = 0;
    movf  = 1'b0;
  endfunction

  // One clock: check head against the model, predict this edge, advance, check flags.
  task automatic tick(input string tag);
    int   pkt;
    logic hl;
    logic pop_m, push_m;
    ent_t e;
    pkt = (sel == 2'd0) ? 16 : ((sel == 2'd1) ? 4 : 0);
    hl  = 1'b0;
    if (sb.size() != 0) hl = sb[0].last || (pkt != 0 && mbeat == pkt - 1);
    chk({tag, " tvalid"}, 65'(obs_tvalid), 65'(sb.size() != 0));
    chk({tag, " tlast"},  65'(obs_tlast),  65'(hl));
    if (sb.size() != 0) chk({tag, " tdata"}, 65'(obs_tdata), 65'(sb[0].data));
    pop_m  = (sb.size() != 0) && tready;
    push_m = write && (sb.size() != 16);
    if (write && sb.size() == 16) movf = 1'b1;
    if (pop_m) begin
      npop++;
      if (hl) begin
        mbeat = 0;
        nlast++;
      end else begin
        mbeat++;
      end
      e = sb.pop_front();
    end
    if (push_m) sb.push_back('{data: din, last: wr_last});
    @(posedge clk);
    @(negedge clk);
    chk_flags(tag);
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1; write = 1'b1; tready = 1'b1; din = 64'hDEAD_0000_0000_BEEF;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0; write = 1'b0; tready = 1'b0;
    model_reset();
    chk({tag, " tvalid"}, 65'(obs_tvalid), 65'(1'b0));
    chk_flags(tag);
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; sel = 2'd0;
    din = 64'd0; wr_last = 1'b0; write = 1'b0; tready = 1'b0;
    @(negedge clk);
    chk("rst tvalid", 65'(obs_tvalid), 65'(1'b0));
    chk("rst tlast",  65'(obs_tlast),  65'(1'b0));
    chk_flags("rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 1: four back-to-back pushes drain in order
    tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      write = 1'b1; din = 64'hA000_0000_0000_0000 + 64'(i);
      tick("t1 push");
      if (i == 0) chk("t1 tvalid rise", 65'(obs_tvalid), 65'(1'b1));
    end
    write = 1'b0;
    repeat (6) tick("t1 drain");
    chk("t1 empty after", 65'(obs_empty), 65'(1'b1));

    // 2: fill to 16 with tready low, 17th dropped, then drain exactly 16
    tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      write = 1'b1; din = 64'hB000_0000_0000_0100 + 64'(i);
      tick("t2 fill");
      if (i == 15) begin
        chk("t2 full", 65'(obs_full), 65'(1'b1));
        chk("t2 count16", 65'(obs_count), 65'(5'd16));
      end
    end
    chk("t2 overflow", 65'(obs_ovf), 65'(1'b1));
    write = 1'b0; tready = 1'b1;
    base_pop = npop;
    repeat (20) tick("t2 drain");
    chk("t2 pops", 65'(npop - base_pop), 65'(16));

    // 5: full with push+pop together, then half-full push+pop
    do_clear("t5 pre-clear");
    tready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      write = 1'b1; din = 64'hC000_0000_0000_0200 + 64'(i);
      tick("t5 fill");
    end
    tready = 1'b1; write = 1'b1; din = 64'hC0FF_EEC0_FFEE_C0FF;
    tick("t5 full push+pop");
    chk("t5 count15", 65'(obs_count), 65'(5'd15));
    chk("t5 overflow", 65'(obs_ovf), 65'(1'b1));
    write = 1'b0;
    repeat (7) tick("t5 part drain");
    for (int i = 0; i < 3; i++) begin
      write = 1'b1; din = 64'hC100_0000_0000_0300 + 64'(i);
      tick("t5 half push+pop");
      chk("t5 count8", 65'(obs_count), 65'(5'd8));
    end
    write = 1'b0; tready = 1'b0;

    // 6: async reset mid-drain with five words queued
    do_clear("t6 pre-clear");
    for (int i = 0; i < 5; i++) begin
      write = 1'b1; din = 64'hD000_0000_0000_0400 + 64'(i);
      tick("t6 fill");
    end
    write = 1'b0; tready = 1'b1;
    tick("t6 drain");
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("t6 rst tvalid", 65'(obs_tvalid), 65'(1'b0));
    chk_flags("t6 rst");
    @(negedge clk);
    reset = 1'b1; tready = 1'b0;
    @(negedge clk);
    // clear after an overflow, with a push and pop attempted in the same cycle
    for (int i = 0; i < 17; i++) begin
      write = 1'b1; din = 64'hD100_0000_0000_0500 + 64'(i);
      tick("t6 overfill");
    end
    write = 1'b0;
    chk("t6 ovf set", 65'(obs_ovf), 65'(1'b1));
    do_clear("t6 clear");
    tick("t6 idle");

    // 3: PKT_BEATS=4, eight unmarked beats -> tlast on beats 3 and 7
    sel = 2'd1; tready = 1'b1; wr_last = 1'b0;
    base_last = nlast;
    for (int i = 0; i < 8; i++) begin
      write = 1'b1; din = 64'hE000_0000_0000_0600 + 64'(i);
      tick("t3 stream");
    end
    write = 1'b0;
    repeat (4) tick("t3 drain");
    chk("t3 tlast count", 65'(nlast - base_last), 65'(2));
    chk("t3 beat wrap", 65'(mbeat), 65'(0));

    // 4: PKT_BEATS=0, framing only from wr_last on word 2
    sel = 2'd2;
    base_last = nlast;
    for (int i = 0; i < 3; i++) begin
      write = 1'b1; wr_last = (i == 2); din = 64'hF000_0000_0000_0700 + 64'(i);
      tick("t4 stream");
    end
    write = 1'b0; wr_last = 1'b0;
    repeat (4) tick("t4 drain");
    chk("t4 tlast count", 65'(nlast - base_last), 65'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
